mnist_class_decision: RTL and testbench
=======================================

# mnist_class_decision

Downstream stage of the MNIST LUT classifier network. Consumes the network's per-beat binary output (CLASS_NUM × CHANNEL_NUM bits plus user sideband), popcounts votes per class across channels, and optionally accumulates them over FRAME_NUM consecutive beats (binary-modulation frames). It then selects the winning class by pipelined argmax and compares it with the label carried in the user sideband. Optional running accuracy counters provide a synthesizable on-chip replacement for bench-side scoring.

## Interface
Parameters:
- USER_WIDTH, 8, user sideband width; low INDEX_WIDTH bits are the ground-truth label
- CLASS_NUM, 10, number of classes
- CHANNEL_NUM, 1, spatial copies per class; in_data bit j*CLASS_NUM+i votes for class i
- FRAME_NUM, 1, beats accumulated per decision (≥1)
- INDEX_WIDTH, 4, class index width (2^INDEX_WIDTH ≥ CLASS_NUM)
- COUNTER_WIDTH, 32, accuracy counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cke  in  1  clock enable; all state holds when 0
- in_last  in  1  final beat of the data set; closes the current frame group
- in_user  in  USER_WIDTH  sideband, label in [INDEX_WIDTH-1:0]
- in_data  in  CLASS_NUM*CHANNEL_NUM  network output bits
- in_valid  in  1  beat qualifier (no backpressure; every valid beat is accepted)
- out_last  out  1  decision closes an in_last group
- out_user  out  USER_WIDTH  user of the group's final beat
- out_class  out  INDEX_WIDTH  winning class
- out_none  out  1  all class scores zero
- out_match  out  1  !out_none && out_class == label
- out_valid  out  1  decision strobe (one cycle)
- count_clear  in  1  synchronous clear of accuracy counters
- out_data_count  out  COUNTER_WIDTH  decisions seen
- out_ok_count  out  COUNTER_WIDTH  matching decisions

## Operation
- SUM_WIDTH = clog2(CHANNEL_NUM*FRAME_NUM+1); all scores unsigned SUM_WIDTH; no saturation needed.
- S1: per class, popcount of CHANNEL_NUM bits, registered with valid/user/last.
- S2 accumulator: frame counter 0..FRAME_NUM-1. Beat at count 0 loads scores, others add. Group ends when count==FRAME_NUM-1 or last=1; then count returns to 0 and a group-valid pulse with the final beat's user/last is issued. Invalid beats do not advance count.
- S3 argmax: strict greater-than scan from index 0 → ties resolve to lowest index; all-zero → out_class=0, out_none=1, out_match=0.
- Counters (when compiled in): on out_valid, data_count+1, ok_count+out_match; modulo 2^COUNTER_WIDTH wrap. count_clear with out_valid in the same cycle → counters load 1 and out_match.
- Reset: all valid flags, frame count, accumulators, out_* and counters → 0.

## Timing
- Latency: group-final beat accepted at edge t → out_valid high after edge t+3; FRAME_NUM=1 gives a fixed 3-cycle pipeline, full throughput (one decision per beat).
- Counters reflect a decision one cycle after its out_valid.
- cke=0 freezes every stage including out_valid (strobe stretches; consumers qualify with cke).
- Reset asserted mid-frame discards partial accumulation; first post-reset beat starts a new group at count 0.
- in_last on a mid-frame beat emits a short group (fewer than FRAME_NUM beats) normally.

## Configuration
- MNIST_CLASS_DECISION_COUNTER_EN defined: counters implemented as above.
- Undefined: counter logic removed; out_data_count and out_ok_count tied to 0; count_clear ignored. Decision path unchanged.

## Test plan
- FRAME_NUM=1, CHANNEL_NUM=1: in_data one-hot bit 7, label 7 → 3 cycles later out_class=7, out_match=1, out_none=0.
- CHANNEL_NUM=4, classes 2 and 5 each get 3 votes, label 5 → out_class=2 (tie to lowest), out_match=0.
- FRAME_NUM=4: four beats voting class 3 = {1,0,1,1}, class 8 = {1,1,0,0} → single out_valid after the 4th beat, out_class=3; no strobe on beats 1-3.
- All-zero in_data → out_none=1, out_class=0, out_match=0, data_count+1, ok_count unchanged.
- 10000 back-to-back beats, in_last on final, 9000 matching → out_last on last decision, counters 10000/9000; count_clear with concurrent match → counters 1/1.
- Reset asserted after 2 of 4 frame beats, then 4 fresh beats → exactly one decision reflecting only the fresh beats.

Source files
------------

// File: rtl/mnist_class_decision.sv
// mnist_class_decision
//   Class decision stage behind the MNIST LUT network. Each beat's per-class
//   votes are popcounted across channels. Votes are accumulated over up to
//   FRAME_NUM beats, or fewer when in_last closes a group early. The winning
//   class is then picked by a two-stage argmax and checked against the label
//   in the low INDEX_WIDTH bits of the user sideband.
//
//   Optional feature macro: MNIST_CLASS_DECISION_COUNTER_EN
//     defined   -> running decision / correct-decision counters
//     undefined -> counters tied to zero, count_clear ignored
//
//   Ports:
//     clk, reset (async, active-high), cke (global clock enable)
//     in_valid/in_last/in_user/in_data          : network beat, no backpressure
//     out_valid/out_last/out_user/out_class     : decision strobe and payload
//     out_none/out_match                        : all-zero scores / label hit
//     count_clear, out_data_count, out_ok_count : accuracy counters
//
//   Pipeline: S1 popcount -> S2 frame accumulate -> S3 half-argmax -> S4 merge.
module mnist_class_decision #(
    parameter int unsigned USER_WIDTH    = 8,
    parameter int unsigned CLASS_NUM     = 10,
    parameter int unsigned CHANNEL_NUM   = 1,
    parameter int unsigned FRAME_NUM     = 1,
    parameter int unsigned INDEX_WIDTH   = 4,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cke,
    input  logic                             in_last,
    input  logic [USER_WIDTH-1:0]            in_user,
    input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
    input  logic                             in_valid,
    output logic                             out_last,
    output logic [USER_WIDTH-1:0]            out_user,
    output logic [INDEX_WIDTH-1:0]           out_class,
    output logic                             out_none,
    output logic                             out_match,
    output logic                             out_valid,
    input  logic                             count_clear,
    output logic [COUNTER_WIDTH-1:0]         out_data_count,
    output logic [COUNTER_WIDTH-1:0]         out_ok_count
);

    localparam int unsigned SUM_W  = $clog2(CHANNEL_NUM * FRAME_NUM + 1);
    localparam int unsigned FCNT_W = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
    localparam int unsigned LO_NUM = (CLASS_NUM + 1) / 2;

    // ---------------- S1: per-class popcount ----------------
    logic [SUM_W-1:0]      s1_score_d [CLASS_NUM];
    logic [SUM_W-1:0]      s1_score_q [CLASS_NUM];
    logic                  s1_valid_d, s1_valid_q;
    logic                  s1_last_d,  s1_last_q;
    logic [USER_WIDTH-1:0] s1_user_d,  s1_user_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < CLASS_NUM; gi++) begin : g_pop
            logic [CHANNEL_NUM-1:0] votes;
            for (gj = 0; gj < CHANNEL_NUM; gj++) begin : g_ch
                assign votes[gj] = in_data[gj*CLASS_NUM + gi];
            end
            assign s1_score_d[gi] = SUM_W'($countones(votes));
        end
    endgenerate

    always_comb begin
        s1_valid_d = in_valid;
        s1_last_d  = in_last;
        s1_user_d  = in_user;
    end

    // ---------------- S2: frame accumulator ----------------
    logic [FCNT_W-1:0]     fcnt_d, fcnt_q;
    logic [SUM_W-1:0]      acc_d [CLASS_NUM];
    logic [SUM_W-1:0]      acc_q [CLASS_NUM];
    logic                  grp_valid_d, grp_valid_q;
    logic                  grp_last_d,  grp_last_q;
    logic [USER_WIDTH-1:0] grp_user_d,  grp_user_q;
    logic                  grp_end_c;

    always_comb begin
        acc_d       = acc_q;
        fcnt_d      = fcnt_q;
        grp_valid_d = 1'b0;
        grp_last_d  = grp_last_q;
        grp_user_d  = grp_user_q;
        grp_end_c   = (fcnt_q == FCNT_W'(FRAME_NUM - 1)) || s1_last_q;
        if (s1_valid_q) begin
            // first beat of a group overwrites, later beats add
            for (int unsigned i = 0; i < CLASS_NUM; i++) begin
                acc_d[i] = (fcnt_q == '0) ? s1_score_q[i] : acc_q[i] + s1_score_q[i];
            end
            grp_valid_d = grp_end_c;
            grp_last_d  = s1_last_q;
            grp_user_d  = s1_user_q;
            fcnt_d      = grp_end_c ? '0 : fcnt_q + FCNT_W'(1);
        end
    end

    // ---------------- S3: argmax of each half ----------------
    logic [SUM_W-1:0]       lo_score_d, lo_score_q, hi_score_d, hi_score_q;
    logic [INDEX_WIDTH-1:0] lo_idx_d, lo_idx_q, hi_idx_d, hi_idx_q;
    logic                   s3_valid_d, s3_valid_q;
    logic                   s3_last_d,  s3_last_q;
    logic [USER_WIDTH-1:0]  s3_user_d,  s3_user_q;

    always_comb begin
        // strict greater-than keeps the lowest index on ties
        lo_score_d = '0;
        lo_idx_d   = '0;
        for (int unsigned i = 0; i < LO_NUM; i++) begin
            if (acc_q[i] > lo_score_d) begin
                lo_score_d = acc_q[i];
                lo_idx_d   = INDEX_WIDTH'(i);
            end
        end
        hi_score_d = '0;
        hi_idx_d   = INDEX_WIDTH'(LO_NUM);
        for (int unsigned i = LO_NUM; i < CLASS_NUM; i++) begin
            if (acc_q[i] > hi_score_d) begin
                hi_score_d = acc_q[i];
                hi_idx_d   = INDEX_WIDTH'(i);
            end
        end
        s3_valid_d = grp_valid_q;
        s3_last_d  = grp_last_q;
        s3_user_d  = grp_user_q;
    end

    // ---------------- S4: merge halves, label compare ----------------
    logic                   out_valid_d, out_valid_q;
    logic                   out_last_d,  out_last_q;
    logic [USER_WIDTH-1:0]  out_user_d,  out_user_q;
    logic [INDEX_WIDTH-1:0] out_class_d, out_class_q;
    logic                   out_none_d,  out_none_q;
    logic                   out_match_d, out_match_q;
    logic                   take_hi_c;
    logic                   none_c;
    logic [INDEX_WIDTH-1:0] win_idx_c;

    always_comb begin
        // the upper half must beat the lower half strictly to win a tie
        take_hi_c   = hi_score_q > lo_score_q;
        none_c      = (lo_score_q == '0) && (hi_score_q == '0);
        win_idx_c   = none_c ? '0 : (take_hi_c ? hi_idx_q : lo_idx_q);
        out_valid_d = s3_valid_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        out_class_d = out_class_q;
        out_none_d  = out_none_q;
        out_match_d = out_match_q;
        if (s3_valid_q) begin
            out_last_d  = s3_last_q;
            out_user_d  = s3_user_q;
            out_class_d = win_idx_c;
            out_none_d  = none_c;
            out_match_d = !none_c && (win_idx_c == s3_user_q[INDEX_WIDTH-1:0]);
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_score_q  <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_user_q   <= '0;
            acc_q       <= '{default: '0};
            fcnt_q      <= '0;
            grp_valid_q <= 1'b0;
            grp_last_q  <= 1'b0;
            grp_user_q  <= '0;
            lo_score_q  <= '0;
            lo_idx_q    <= '0;
            hi_score_q  <= '0;
            hi_idx_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_user_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            out_class_q <= '0;
            out_none_q  <= 1'b0;
            out_match_q <= 1'b0;
        end else if (cke) begin
            s1_score_q  <= s1_score_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_user_q   <= s1_user_d;
            acc_q       <= acc_d;
            fcnt_q      <= fcnt_d;
            grp_valid_q <= grp_valid_d;
            grp_last_q  <= grp_last_d;
            grp_user_q  <= grp_user_d;
            lo_score_q  <= lo_score_d;
            lo_idx_q    <= lo_idx_d;
            hi_score_q  <= hi_score_d;
            hi_idx_q    <= hi_idx_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            s3_user_q   <= s3_user_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            out_class_q <= out_class_d;
            out_none_q  <= out_none_d;
            out_match_q <= out_match_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_user  = out_user_q;
    assign out_class = out_class_q;
    assign out_none  = out_none_q;
    assign out_match = out_match_q;

    // ---------------- accuracy counters ----------------
`ifdef MNIST_CLASS_DECISION_COUNTER_EN
    logic [COUNTER_WIDTH-1:0] data_cnt_d, data_cnt_q;
    logic [COUNTER_WIDTH-1:0] ok_cnt_d,   ok_cnt_q;

    always_comb begin
        data_cnt_d = data_cnt_q;
        ok_cnt_d   = ok_cnt_q;
        if (count_clear) begin
            // a decision in the clearing cycle becomes the first one counted
            data_cnt_d = COUNTER_WIDTH'(out_valid_q);
            ok_cnt_d   = COUNTER_WIDTH'(out_valid_q && out_match_q);
        end else if (out_valid_q) begin
            data_cnt_d = data_cnt_q + COUNTER_WIDTH'(1);
            ok_cnt_d   = ok_cnt_q + COUNTER_WIDTH'(out_match_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_cnt_q <= '0;
            ok_cnt_q   <= '0;
        end else if (cke) begin
            data_cnt_q <= data_cnt_d;
            ok_cnt_q   <= ok_cnt_d;
        end
    end

    assign out_data_count = data_cnt_q;
    assign out_ok_count   = ok_cnt_q;
`else
    logic unused_count_clear;
    assign unused_count_clear = count_clear;
    assign out_data_count     = '0;
    assign out_ok_count       = '0;
`endif

endmodule

// File: tb/tb_mnist_class_decision.sv
// tb_mnist_class_decision
//   Scoreboard bench: the driver feeds beats into a behavioural vote model
//   that pushes one expected decision per closed group; a negedge monitor
//   pops and compares whenever the DUT presents out_valid with cke high,
//   and tracks the expected accuracy counters.
module tb_mnist_class_decision;

    localparam int unsigned USER_W = 8;
    localparam int unsigned CLS    = 10;
    localparam int unsigned CH     = 4;
    localparam int unsigned FRM    = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DW     = CLS * CH;
`ifdef MNIST_CLASS_DECISION_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cke = 1'b1;
    logic              in_last = 1'b0;
    logic [USER_W-1:0] in_user = '0;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              count_clear = 1'b0;
    logic              out_last, out_none, out_match, out_valid;
    logic [USER_W-1:0] out_user;
    logic [IDX_W-1:0]  out_class;
    logic [CNT_W-1:0]  out_data_count, out_ok_count;

    mnist_class_decision #(
        .USER_WIDTH(USER_W), .CLASS_NUM(CLS), .CHANNEL_NUM(CH),
        .FRAME_NUM(FRM), .INDEX_WIDTH(IDX_W), .COUNTER_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .in_last(in_last), .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
        .out_last(out_last), .out_user(out_user), .out_class(out_class),
        .out_none(out_none), .out_match(out_match), .out_valid(out_valid),
        .count_clear(count_clear),
        .out_data_count(out_data_count), .out_ok_count(out_ok_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]  cls;
        logic              none;
        logic              match;
        logic              last;
        logic [USER_W-1:0] user;
        int unsigned       acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_acc[CLS];
    int          m_fcnt = 0;
    longint      m_data = 0;
    longint      m_ok   = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // enabled-cycle count, used to measure latency independent of stalls
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else if (cke) cyc <= cyc + 1;
    end

    // vote model: sum votes over the group, argmax with lowest-index ties
    function automatic void model_beat(input logic [DW-1:0] d, input logic [USER_W-1:0] u,
                                       input logic l);
        exp_t e;
        int   best;
        int   bi;
        if (m_fcnt == 0) foreach (m_acc[i]) m_acc[i] = 0;
        for (int i = 0; i < CLS; i++)
            for (int j = 0; j < CH; j++)
                m_acc[i] += int'(d[j*CLS + i]);
        if (m_fcnt == FRM - 1 || l) begin
            best = 0;
            bi   = 0;
            for (int i = 0; i < CLS; i++)
                if (m_acc[i] > best) begin best = m_acc[i]; bi = i; end
            e.none    = (best == 0);
            e.cls     = IDX_W'(bi);
            e.match   = !e.none && (bi == int'(u[IDX_W-1:0]));
            e.last    = l;
            e.user    = u;
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
            m_fcnt = 0;
        end else begin
            m_fcnt++;
        end
    endfunction

    function automatic int beat_winner(input logic [DW-1:0] d);
        int c[CLS];
        int best;
        int bi;
        best = 0;
        bi   = 0;
        for (int i = 0; i < CLS; i++) begin
            c[i] = 0;
            for (int j = 0; j < CH; j++) c[i] += int'(d[j*CLS + i]);
            if (c[i] > best) begin best = c[i]; bi = i; end
        end
        return bi;
    endfunction

    task automatic drive(input logic [DW-1:0] d, input logic [USER_W-1:0] u, input logic l,
                         input logic v, input logic ck, input logic clr);
        in_data     = d;
        in_user     = u;
        in_last     = l;
        in_valid    = v;
        cke         = ck;
        count_clear = clr;
        if (v && ck) model_beat(d, u, l);
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [USER_W-1:0] u, input logic l);
        drive(d, u, l, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb_q.size() != 0; k++) idle();
        chk("drain_pending", 64'(sb_q.size()), 64'd0);
        repeat (2) idle();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        count_clear = 1'b0;
        cke      = 1'b1;
        m_fcnt   = 0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // monitor: counter check, then consume a decision if cke lets it go
    exp_t mon_e;
    logic mon_have;
    always @(negedge clk) begin
        if (reset) begin
            m_data = 0;
            m_ok   = 0;
        end else begin
            chk("data_count", 64'(out_data_count), 64'(m_data));
            chk("ok_count", 64'(out_ok_count), 64'(m_ok));
            if (cke) begin
                mon_have = 1'b0;
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_valid", 64'd1, 64'd0);
                    end else begin
                        mon_e    = sb_q.pop_front();
                        mon_have = 1'b1;
                        chk("class", 64'(out_class), 64'(mon_e.cls));
                        chk("none", 64'(out_none), 64'(mon_e.none));
                        chk("match", 64'(out_match), 64'(mon_e.match));
                        chk("user", 64'(out_user), 64'(mon_e.user));
                        chk("last", 64'(out_last), 64'(mon_e.last));
                        chk("latency", 64'(cyc), 64'(mon_e.acc_cyc + 3));
                    end
                end
                if (CNT_EN) begin
                    if (count_clear) begin
                        m_data = mon_have ? 1 : 0;
                        m_ok   = (mon_have && mon_e.match) ? 1 : 0;
                    end else if (mon_have) begin
                        m_data++;
                        m_ok += mon_e.match ? 1 : 0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0]     d;
        logic [USER_W-1:0] u;
        int                w;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_class", 64'(out_class), 64'd0);
        chk("rst_none", 64'(out_none), 64'd0);
        chk("rst_match", 64'(out_match), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_user", 64'(out_user), 64'd0);
        chk("rst_data_count", 64'(out_data_count), 64'd0);
        chk("rst_ok_count", 64'(out_ok_count), 64'd0);
        do_reset();

        // single vote for class 7, label 7
        d = '0; d[7] = 1'b1;
        beat(d, 8'd7, 1'b1);
        // classes 2 and 5 tie at 3 votes, label 5 -> lowest index wins
        d = '0; d[2] = 1'b1; d[12] = 1'b1; d[22] = 1'b1;
        d[5] = 1'b1; d[15] = 1'b1; d[25] = 1'b1;
        beat(d, 8'd5, 1'b1);
        // full frame: class 3 = {1,0,1,1}, class 8 = {1,1,0,0}
        d = '0; d[3] = 1'b1; d[8] = 1'b1; beat(d, 8'h23, 1'b0);
        d = '0; d[8] = 1'b1;              beat(d, 8'h23, 1'b0);
        d = '0; d[3] = 1'b1;              beat(d, 8'h23, 1'b0);
        d = '0; d[3] = 1'b1;              beat(d, 8'h43, 1'b0);
        // all-zero scores with label 0
        beat('0, 8'h00, 1'b1);
        // short group closed by in_last on its second beat
        d = '0; d[39] = 1'b1; beat(d, 8'd9, 1'b0);
        d = '0; d[19] = 1'b1; beat(d, 8'h89, 1'b1);
        drain();

        // randomized traffic with stalls, gaps, early last and clears
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < int'(DW); b++) d[b] = ($urandom % 5 == 0);
            u = USER_W'($urandom);
            drive(d, u, ($urandom % 6 == 0), ($urandom % 4 != 0), ($urandom % 5 != 0),
                  ($urandom % 60 == 0));
        end
        beat('0, 8'd1, 1'b1);
        drain();

        // 10000 back-to-back single-beat decisions, 9000 matching
        drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10000; k++) begin
            for (int b = 0; b < int'(DW); b++) d[b] = ($urandom % 4 == 0);
            d[$urandom_range(CLS - 1, 0)] = 1'b1;
            w = beat_winner(d);
            u = (k % 10 == 0) ? USER_W'(w + 1) : USER_W'(w);
            u[7:4] = 4'($urandom);
            beat(d, u, 1'b1);
        end
        drain();
        chk("bulk_data_count", 64'(out_data_count), CNT_EN ? 64'd10000 : 64'd0);
        chk("bulk_ok_count", 64'(out_ok_count), CNT_EN ? 64'd9000 : 64'd0);

        // clear coinciding with a matching decision
        d = '0; d[4] = 1'b1; d[14] = 1'b1;
        beat(d, 8'd4, 1'b1);
        for (int k = 0; k < 10 && !out_valid; k++) idle();
        chk("clear_wait_valid", 64'(out_valid), 64'd1);
        drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2) idle();
        chk("clear_data_count", 64'(out_data_count), CNT_EN ? 64'd1 : 64'd0);
        chk("clear_ok_count", 64'(out_ok_count), CNT_EN ? 64'd1 : 64'd0);

        // reset after two of four beats; stale class-9 votes must be discarded
        d = '0; d[9] = 1'b1; d[19] = 1'b1; d[29] = 1'b1; d[39] = 1'b1;
        beat(d, 8'd9, 1'b0);
        beat(d, 8'd9, 1'b0);
        do_reset();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_data_count", 64'(out_data_count), 64'd0);
        d = '0; d[1] = 1'b1;
        for (int k = 0; k < 4; k++) beat(d, 8'd1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
